// File: rtl/lights_pio_pkg.sv
// =============================================================================
// lights_pio_pkg : register map and edge-type constants for lights_buttons
// Revision: 1.0
// =============================================================================
`default_nettype none

package lights_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_RSVD    = 2'd1,
      REG_IRQMASK = 2'd2,
      REG_EDGECAP = 2'd3
   } reg_addr_e;

   // Counter width for a debounce window; never narrower than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lights_debounce_bit.sv
// =============================================================================
// lights_debounce_bit : 2-flop synchroniser plus stability counter for one input
// Revision: 1.0
// =============================================================================
`default_nettype none

module lights_debounce_bit
   import lights_pio_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_VALUE     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          deb_q,   deb_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   // Any matching cycle restarts the window, so short glitches never accumulate.
   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = cnt_q;
      if (sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         deb_d = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= RESET_VALUE;
         sync2_q <= RESET_VALUE;
         deb_q   <= RESET_VALUE;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = deb_q;

endmodule

`default_nettype wire

// File: rtl/lights_buttons.sv
// =============================================================================
// lights_buttons : Avalon-MM button/switch input port with debounce, edge
//                  capture and maskable level interrupt
// Revision: 1.0
// =============================================================================
`default_nettype none

module lights_buttons
   import lights_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] edge_vec;
   logic [WIDTH-1:0] clr;
   logic             wr_en;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         lights_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
         ) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (in_port[i]),
            .dout  (deb[i])
         );
      end
   endgenerate

   generate
      if (WIDTH < 32) begin : g_wd_unused
         logic unused_wd;
         assign unused_wd = ^writedata[31:WIDTH];
      end
   endgenerate

   assign wr_en = chipselect & ~write_n;

   always_comb begin
      edge_vec = '0;
      if (EDGE_TYPE == EDGE_RISE) begin
         edge_vec = deb & ~deb_dly_q;
      end else if (EDGE_TYPE == EDGE_FALL) begin
         edge_vec = ~deb & deb_dly_q;
      end else begin
         edge_vec = deb ^ deb_dly_q;
      end
   end

   // Clear is applied before the set so a simultaneous edge is never lost.
   always_comb begin
      clr       = '0;
      deb_dly_d = deb;
      irqmask_d = irqmask_q;
      if (wr_en && address == ADDR_EDGECAP) begin
         clr = writedata[WIDTH-1:0];
      end
      if (wr_en && address == ADDR_IRQMASK) begin
         irqmask_d = writedata[WIDTH-1:0];
      end
      edgecap_d = (edgecap_q & ~clr) | edge_vec;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb_dly_q <= RESET_VALUE;
         irqmask_q <= '0;
         edgecap_q <= '0;
      end else begin
         deb_dly_q <= deb_dly_d;
         irqmask_q <= irqmask_d;
         edgecap_q <= edgecap_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = deb;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
         default:      readdata            = '0;
      endcase
   end

   assign irq = |(edgecap_q & irqmask_q);

endmodule

`default_nettype wire
